// File: rtl/matriz_controlador.sv
// ---------------------------------------------------------------------------
// matriz_controlador
//
// Sequencer for the matrix coprocessor ALU. It takes one command at a time,
// fetches one or two operand matrices from matrix memory, drives the ALU
// start/done handshake and writes the 200-bit result back to memory. It is
// the only master of both the ALU and the matrix memory.
//
// Optional feature macro: MTX_PERF_CNT_EN
//   defined   -> perf_ops_o counts successfully completed commands (wraps)
//   undefined -> perf_ops_o is tied to zero and no counter flops exist
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   cmd_valid_i         command present
//   cmd_ready_o         high only while idle; accept = valid & ready
//   cmd_opcode_i        ALU opcode (legal 4'h3..4'h7)
//   cmd_addr_a_i/_b_i   source matrix addresses
//   cmd_addr_d_i        destination matrix address
//   cmd_scalar_i        scalar operand
//   mem_addr_o          memory address for read or write
//   mem_rd_en_o         read strobe, data returns one cycle later
//   mem_rdata_i         read data
//   mem_wr_en_o         one-cycle write strobe
//   mem_wdata_o         write data (captured ALU result)
//   alu_opcode_o        latched opcode
//   alu_scalar_o        latched scalar
//   alu_mat_a_o/_b_o    operand registers
//   alu_start_o         level start, held until done or timeout
//   alu_result_i        ALU result
//   alu_done_i          ALU done
//   busy_o              not idle
//   rsp_valid_o         one-cycle completion pulse
//   rsp_error_o         qualified by rsp_valid_o: illegal opcode or timeout
//   perf_ops_o          completed-command counter
// ---------------------------------------------------------------------------
module matriz_controlador #(
    parameter int ADDR_W  = 8,
    parameter int MAT_W   = 200,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_opcode_i,
    input  logic [ADDR_W-1:0] cmd_addr_a_i,
    input  logic [ADDR_W-1:0] cmd_addr_b_i,
    input  logic [ADDR_W-1:0] cmd_addr_d_i,
    input  logic [7:0]        cmd_scalar_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    input  logic [MAT_W-1:0]  mem_rdata_i,
    output logic              mem_wr_en_o,
    output logic [MAT_W-1:0]  mem_wdata_o,
    output logic [3:0]        alu_opcode_o,
    output logic [7:0]        alu_scalar_o,
    output logic [MAT_W-1:0]  alu_mat_a_o,
    output logic [MAT_W-1:0]  alu_mat_b_o,
    output logic              alu_start_o,
    input  logic [MAT_W-1:0]  alu_result_i,
    input  logic              alu_done_i,
    output logic              busy_o,
    output logic              rsp_valid_o,
    output logic              rsp_error_o,
    output logic [15:0]       perf_ops_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP,
        EXEC,
        WB,
        RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_a_q, addr_b_q, addr_d_q;
    logic [3:0]         opcode_q;
    logic [7:0]         scalar_q;
    logic [MAT_W-1:0]   mat_a_q, mat_b_q, wdata_q;

    logic accept;
    logic cmd_legal;
    logic two_op;

    assign accept    = (state_q == IDLE) && cmd_valid_i;
    assign cmd_legal = (cmd_opcode_i >= 4'h3) && (cmd_opcode_i <= 4'h7);
    // Opcodes 3..5 read both sources; 6 and 7 work on source A only.
    assign two_op    = (opcode_q >= 4'h3) && (opcode_q <= 4'h5);

    assign alu_opcode_o = opcode_q;
    assign alu_scalar_o = scalar_q;
    assign alu_mat_a_o  = mat_a_q;
    assign alu_mat_b_o  = mat_b_q;
    assign mem_wdata_o  = wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode. The timeout counter only runs in EXEC
    // and is zero on every entry. alu_done is tested ahead of the timeout
    // so a done arriving on the last allowed cycle still counts as success.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        cnt_d       = '0;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        mem_addr_o  = '0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        alu_start_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_error_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    if (cmd_legal) begin
                        state_d = RD_A;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        err_d   = 1'b1;
                    end
                end
            end
            RD_A: begin
                mem_addr_o  = addr_a_q;
                mem_rd_en_o = 1'b1;
                state_d     = two_op ? RD_B : CAP;
            end
            RD_B: begin
                mem_addr_o  = addr_b_q;
                mem_rd_en_o = 1'b1;
                state_d     = CAP;
            end
            CAP: begin
                state_d = EXEC;
            end
            EXEC: begin
                alu_start_o = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (alu_done_i) begin
                    state_d = WB;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RELEASE;
                    err_d   = 1'b1;
                end
            end
            WB: begin
                mem_addr_o  = addr_d_q;
                mem_wr_en_o = 1'b1;
                state_d     = RELEASE;
            end
            RELEASE: begin
                // Hold off the response until the ALU has dropped done, so
                // the next command never sees a stale done.
                if (!alu_done_i) begin
                    rsp_valid_o = 1'b1;
                    rsp_error_o = err_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command fields are latched at acceptance; operands are captured from
    // the read data one cycle after each read strobe, so a destination equal
    // to a source is safe because both reads finish before WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            scalar_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_d_q <= '0;
            mat_a_q  <= '0;
            mat_b_q  <= '0;
            wdata_q  <= '0;
        end else begin
            if (accept) begin
                opcode_q <= cmd_opcode_i;
                scalar_q <= cmd_scalar_i;
                addr_a_q <= cmd_addr_a_i;
                addr_b_q <= cmd_addr_b_i;
                addr_d_q <= cmd_addr_d_i;
            end
            if (state_q == RD_B) begin
                mat_a_q <= mem_rdata_i;
            end
            if (state_q == CAP) begin
                if (two_op) begin
                    mat_b_q <= mem_rdata_i;
                end else begin
                    mat_a_q <= mem_rdata_i;
                    mat_b_q <= '0;
                end
            end
            if ((state_q == EXEC) && alu_done_i) begin
                wdata_q <= alu_result_i;
            end
        end
    end

`ifdef MTX_PERF_CNT_EN
    logic [15:0] perf_q;

    // Counts error-free completions; natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (rsp_valid_o && !rsp_error_o) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_ops_o = perf_q;
`else
    assign perf_ops_o = '0;
`endif

endmodule

// File: tb/tb_matriz_controlador.sv
// ---------------------------------------------------------------------------
// tb_matriz_controlador
//
// Directed bench for matriz_controlador with a behavioural matrix memory
// and a small ALU model (1-cycle done, or never done when aluNoDone is set).
// Runs with TIMEOUT=15.
// ---------------------------------------------------------------------------
module tb_matriz_controlador;

    localparam int ADDR_W = 8;
    localparam int MAT_W  = 200;

    logic              clk;
    logic              rst_n;
    logic              cmdValid;
    logic              cmdReady;
    logic [3:0]        cmdOpcode;
    logic [ADDR_W-1:0] cmdAddrA, cmdAddrB, cmdAddrD;
    logic [7:0]        cmdScalar;
    logic [ADDR_W-1:0] memAddr;
    logic              memRdEn;
    logic [MAT_W-1:0]  memRdata;
    logic              memWrEn;
    logic [MAT_W-1:0]  memWdata;
    logic [3:0]        aluOpcode;
    logic [7:0]        aluScalar;
    logic [MAT_W-1:0]  aluMatA, aluMatB;
    logic              aluStart;
    logic [MAT_W-1:0]  aluResult;
    logic              aluDone;
    logic              busy;
    logic              rspValid;
    logic              rspError;
    logic [15:0]       perfOps;

    logic              aluNoDone;
    logic [MAT_W-1:0]  mem [0:255];

    int checkCount = 0;
    int failCount  = 0;
    int rdCount    = 0;
    int wrCount    = 0;
    int startCount = 0;
    int rspCount   = 0;
    int bothCount  = 0;

    matriz_controlador #(
        .ADDR_W (ADDR_W),
        .MAT_W  (MAT_W),
        .TIMEOUT(15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmdValid),
        .cmd_ready_o (cmdReady),
        .cmd_opcode_i(cmdOpcode),
        .cmd_addr_a_i(cmdAddrA),
        .cmd_addr_b_i(cmdAddrB),
        .cmd_addr_d_i(cmdAddrD),
        .cmd_scalar_i(cmdScalar),
        .mem_addr_o  (memAddr),
        .mem_rd_en_o (memRdEn),
        .mem_rdata_i (memRdata),
        .mem_wr_en_o (memWrEn),
        .mem_wdata_o (memWdata),
        .alu_opcode_o(aluOpcode),
        .alu_scalar_o(aluScalar),
        .alu_mat_a_o (aluMatA),
        .alu_mat_b_o (aluMatB),
        .alu_start_o (aluStart),
        .alu_result_i(aluResult),
        .alu_done_i  (aluDone),
        .busy_o      (busy),
        .rsp_valid_o (rspValid),
        .rsp_error_o (rspError),
        .perf_ops_o  (perfOps)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MAT_W-1:0] fillByte(input logic [7:0] b);
        logic [MAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    // Element-wise reference ALU: 3 add, 4 sub, 5 mul, 6 scalar mul, 7 negate.
    function automatic logic [MAT_W-1:0] aluModel(input logic [3:0] op, input logic [7:0] sc,
                                                  input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        logic [MAT_W-1:0] r;
        logic [7:0] ea, eb;
        r = '0;
        for (int i = 0; i < 25; i++) begin
            ea = a[i*8 +: 8];
            eb = b[i*8 +: 8];
            case (op)
                4'h3:    r[i*8 +: 8] = ea + eb;
                4'h4:    r[i*8 +: 8] = ea - eb;
                4'h5:    r[i*8 +: 8] = ea * eb;
                4'h6:    r[i*8 +: 8] = ea * sc;
                4'h7:    r[i*8 +: 8] = 8'd0 - ea;
                default: r[i*8 +: 8] = 8'd0;
            endcase
        end
        return r;
    endfunction

    assign aluResult = aluModel(aluOpcode, aluScalar, aluMatA, aluMatB);

    // Done follows start by one cycle and clears one cycle after start falls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) aluDone <= 1'b0;
        else        aluDone <= aluNoDone ? 1'b0 : aluStart;
    end

    // Synchronous memory, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (memRdEn) memRdata <= mem[memAddr];
        if (memWrEn) mem[memAddr] <= memWdata;
    end

    // Per-cycle activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (memRdEn)            rdCount++;
        if (memWrEn)            wrCount++;
        if (aluStart)           startCount++;
        if (rspValid)           rspCount++;
        if (memRdEn && memWrEn) bothCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [MAT_W-1:0] observed,
                               input logic [MAT_W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one command from IDLE and wait for its response. lat is the
    // cycle of rsp_valid counted from the accept edge (cycle 0), -1 if none.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] d, input logic [7:0] sc, input int budget,
                                 output int lat, output logic err);
        @(posedge clk);
        #1;
        cmdValid  = 1'b1;
        cmdOpcode = op;
        cmdAddrA  = a;
        cmdAddrB  = b;
        cmdAddrD  = d;
        cmdScalar = sc;
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        lat = -1;
        err = 1'bx;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (rspValid) begin
                lat = n;
                err = rspError;
                break;
            end
        end
    endtask

    int   lat, lat2, accCycle;
    logic err;
    int   rd0, wr0, st0, rsp0;
    logic [15:0] expPerf;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[1] = fillByte(8'h02);
        mem[2] = fillByte(8'h03);
        mem[4] = fillByte(8'h01);
        aluNoDone = 1'b0;
        rst_n     = 1'b0;
        cmdValid  = 1'b0;
        cmdOpcode = '0;
        cmdAddrA  = '0;
        cmdAddrB  = '0;
        cmdAddrD  = '0;
        cmdScalar = '0;

        // Reset state
        #12;
        checkOutput("rst_cmd_ready", MAT_W'(cmdReady), MAT_W'(1));
        checkOutput("rst_busy", MAT_W'(busy), MAT_W'(0));
        checkOutput("rst_rd_wr_start", MAT_W'({memRdEn, memWrEn, aluStart, rspValid}), MAT_W'(0));
        checkOutput("rst_wdata", memWdata, '0);
        checkOutput("rst_perf", MAT_W'(perfOps), MAT_W'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // 1. Two-operand add, 2 + 3 = 5
        rd0 = rdCount; wr0 = wrCount;
        applyStimulus(4'h3, 8'd1, 8'd2, 8'd5, 8'd0, 40, lat, err);
        checkOutput("soma_latency", MAT_W'(lat), MAT_W'(7));
        checkOutput("soma_error", MAT_W'(err), MAT_W'(0));
        @(negedge clk);
        checkOutput("soma_mem5", mem[5], fillByte(8'h05));
        checkOutput("soma_reads", MAT_W'(rdCount - rd0), MAT_W'(2));
        checkOutput("soma_writes", MAT_W'(wrCount - wr0), MAT_W'(1));

        // 2. One-operand negate of all 8'h02
        rd0 = rdCount;
        applyStimulus(4'h7, 8'd1, 8'd9, 8'd7, 8'd0, 40, lat, err);
        checkOutput("oposta_latency", MAT_W'(lat), MAT_W'(6));
        checkOutput("oposta_error", MAT_W'(err), MAT_W'(0));
        checkOutput("oposta_reads", MAT_W'(rdCount - rd0), MAT_W'(1));
        checkOutput("oposta_mat_b", aluMatB, '0);
        @(negedge clk);
        checkOutput("oposta_mem7", mem[7], fillByte(8'hFE));

        // 3. Illegal opcode
        rd0 = rdCount; wr0 = wrCount; st0 = startCount;
        applyStimulus(4'hA, 8'd1, 8'd2, 8'd8, 8'd0, 40, lat, err);
        checkOutput("illegal_latency", MAT_W'(lat), MAT_W'(1));
        checkOutput("illegal_error", MAT_W'(err), MAT_W'(1));
        checkOutput("illegal_activity", MAT_W'((rdCount - rd0) + (wrCount - wr0) + (startCount - st0)), MAT_W'(0));

        // 4. ALU never answers: 15 start cycles then abort
        aluNoDone = 1'b1;
        wr0 = wrCount; st0 = startCount;
        applyStimulus(4'h3, 8'd1, 8'd2, 8'd6, 8'd0, 60, lat, err);
        checkOutput("timeout_latency", MAT_W'(lat), MAT_W'(19));
        checkOutput("timeout_error", MAT_W'(err), MAT_W'(1));
        checkOutput("timeout_start_cycles", MAT_W'(startCount - st0), MAT_W'(15));
        checkOutput("timeout_writes", MAT_W'(wrCount - wr0), MAT_W'(0));
        checkOutput("timeout_start_low", MAT_W'(aluStart), MAT_W'(0));
        @(negedge clk);
        checkOutput("timeout_mem6", mem[6], '0);

        // 5. Reset while in EXEC
        @(posedge clk);
        #1;
        cmdValid = 1'b1; cmdOpcode = 4'h3; cmdAddrA = 8'd1; cmdAddrB = 8'd2; cmdAddrD = 8'd9;
        @(posedge clk);
        #1 cmdValid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("exec_start_before_reset", MAT_W'(aluStart), MAT_W'(1));
        wr0 = wrCount; rsp0 = rspCount;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_start", MAT_W'(aluStart), MAT_W'(0));
        checkOutput("reset_busy", MAT_W'(busy), MAT_W'(0));
        checkOutput("reset_ready", MAT_W'(cmdReady), MAT_W'(1));
        checkOutput("reset_mat_a", aluMatA, '0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        aluNoDone = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_no_rsp", MAT_W'(rspCount - rsp0), MAT_W'(0));
        checkOutput("reset_no_write", MAT_W'(wrCount - wr0), MAT_W'(0));
        checkOutput("reset_perf", MAT_W'(perfOps), MAT_W'(0));

        // 6. Back-to-back, a=d=4: 1+3=4, then 4+3=7
        @(posedge clk);
        #1;
        cmdValid = 1'b1; cmdOpcode = 4'h3; cmdAddrA = 8'd4; cmdAddrB = 8'd2; cmdAddrD = 8'd4;
        @(posedge clk);
        #1;
        cmdScalar = 8'd1;
        accCycle = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (cmdReady) begin
                accCycle = n;
                break;
            end
        end
        checkOutput("b2b_second_accept", MAT_W'(accCycle), MAT_W'(8));
        @(posedge clk);
        #1 cmdValid = 1'b0;
        lat2 = -1;
        err = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rspValid) begin
                lat2 = n;
                err = rspError;
                break;
            end
        end
        checkOutput("b2b_second_latency", MAT_W'(lat2), MAT_W'(7));
        checkOutput("b2b_error", MAT_W'(err), MAT_W'(0));
        @(negedge clk);
        checkOutput("b2b_mem4", mem[4], fillByte(8'h07));
`ifdef MTX_PERF_CNT_EN
        expPerf = 16'd2;
`else
        expPerf = 16'd0;
`endif
        checkOutput("b2b_perf", MAT_W'(perfOps), MAT_W'(expPerf));
        checkOutput("rd_wr_overlap", MAT_W'(bothCount), MAT_W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
